// File: rtl/lfsr_hs_controller.sv
// Clocked sequencer for an asynchronous dual-rail LFSR using a four-phase
// req/ack handshake, with return-to-zero checking and codeword capture.
//
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   start         one-cycle pulse, runs one handshake (IDLE only)
//   auto          chain handshakes back to back (sampled in SETTLE_LO)
//   err_clr       clears sticky error flags and leaves ERR
//   busy          high in every state except IDLE
//   data          last captured codeword {a1,b1,c1}
//   data_valid    one-cycle pulse when data updates
//   err_timeout   sticky, a phase was not reached in time
//   err_code      sticky, an illegal rail pair (x0=x1=1) was seen
//   req           registered request to the LFSR
//   ack           asynchronous acknowledge from the LFSR
//   a0..c1        asynchronous dual-rail LFSR outputs
module lfsr_hs_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       auto,
    input  logic       err_clr,
    output logic       busy,
    output logic [2:0] data,
    output logic       data_valid,
    output logic       err_timeout,
    output logic       err_code,
    output logic       req,
    input  logic       ack,
    input  logic       a0,
    input  logic       a1,
    input  logic       b0,
    input  logic       b1,
    input  logic       c0,
    input  logic       c1
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_TMO  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQ_HI    = 3'd1;
    localparam logic [2:0] S_SETTLE_HI = 3'd2;
    localparam logic [2:0] S_REQ_LO    = 3'd3;
    localparam logic [2:0] S_SETTLE_LO = 3'd4;
    localparam logic [2:0] S_ERR       = 3'd5;

    // Synchroniser chain; bit 6 is ack, bits 5..0 are a0,a1,b0,b1,c0,c1.
    logic [SYNC_STAGES-1:0][6:0] sync_q;
    logic [SYNC_STAGES-1:0][6:0] sync_d;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          req_q;
    logic          req_d;
    logic [2:0]    data_q;
    logic [2:0]    data_d;
    logic          dv_q;
    logic          dv_d;
    logic          err_to_q;
    logic          err_to_d;
    logic          err_code_q;
    logic          err_code_d;

    logic       ack_s;
    logic [5:0] rails_s;
    logic       rails_valid;
    logic       rails_null;
    logic       rails_illegal;
    logic       rtz;
    logic       settle_done;
    logic       capture;
    logic       set_to;
    logic       set_code;
    logic       clr_err;

    always_comb begin
        sync_d[0] = {ack, a0, a1, b0, b1, c0, c1};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign ack_s   = sync_q[SYNC_STAGES-1][6];
    assign rails_s = sync_q[SYNC_STAGES-1][5:0];

    assign rails_valid = (rails_s[5] ^ rails_s[4])
                       & (rails_s[3] ^ rails_s[2])
                       & (rails_s[1] ^ rails_s[0]);

    assign rails_null = ~|rails_s;

    assign rails_illegal = (rails_s[5] & rails_s[4])
                         | (rails_s[3] & rails_s[2])
                         | (rails_s[1] & rails_s[0]);

    // Return-to-zero: the only condition under which req may rise.
    assign rtz = ~ack_s & rails_null;

    assign settle_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        set_to   = 1'b0;
        set_code = 1'b0;
        clr_err  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A start seen while the previous phase is still
                // visible is dropped silently.
                if (start && rtz) begin
                    state_d = S_REQ_HI;
                end
            end
            S_REQ_HI: begin
                if (rails_illegal) begin
                    state_d  = S_ERR;
                    set_code = 1'b1;
                end else if (ack_s && rails_valid) begin
                    state_d = S_SETTLE_HI;
                end else if (cnt_q == CNT_TMO) begin
                    state_d = S_ERR;
                    set_to  = 1'b1;
                end
            end
            S_SETTLE_HI: begin
                if (settle_done) begin
                    if (ack_s && rails_valid) begin
                        state_d = S_REQ_LO;
                        capture = 1'b1;
                    end else if (rails_illegal) begin
                        state_d  = S_ERR;
                        set_code = 1'b1;
                    end else begin
                        // Glitched phase: wait for it again.
                        state_d = S_REQ_HI;
                    end
                end
            end
            S_REQ_LO: begin
                if (rtz) begin
                    state_d = S_SETTLE_LO;
                end else if (cnt_q == CNT_TMO) begin
                    state_d = S_ERR;
                    set_to  = 1'b1;
                end
            end
            S_SETTLE_LO: begin
                if (settle_done) begin
                    // Re-check RTZ so a late bounce never lets req rise.
                    if (!rtz) begin
                        state_d = S_REQ_LO;
                    end else if (auto) begin
                        state_d = S_REQ_HI;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                // Leave via REQ_LO so the LFSR must return to zero first.
                if (err_clr) begin
                    state_d = S_REQ_LO;
                    clr_err = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Cleared on every state change, saturating otherwise.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Setting an error has priority over clearing it.
    always_comb begin
        err_to_d   = err_to_q;
        err_code_d = err_code_q;
        if (clr_err) begin
            err_to_d   = 1'b0;
            err_code_d = 1'b0;
        end
        if (set_to) begin
            err_to_d = 1'b1;
        end
        if (set_code) begin
            err_code_d = 1'b1;
        end
    end

    always_comb begin
        req_d  = (state_d == S_REQ_HI) || (state_d == S_SETTLE_HI);
        dv_d   = capture;
        data_d = capture ? {rails_s[4], rails_s[2], rails_s[0]} : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            data_q     <= 3'b000;
            dv_q       <= 1'b0;
            err_to_q   <= 1'b0;
            err_code_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            err_to_q   <= err_to_d;
            err_code_q <= err_code_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign req         = req_q;
    assign data        = data_q;
    assign data_valid  = dv_q;
    assign err_timeout = err_to_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_lfsr_hs_controller.sv
// Bench for lfsr_hs_controller: a behavioural dual-rail LFSR answers req,
// and captured codewords are compared with the expected LFSR sequence.
module tb_lfsr_hs_controller;

    localparam int SYNC = 2;
    localparam int SET  = 2;
    localparam int TMO  = 255;

    logic clk = 1'b0;
    logic rst_n, start, auto, err_clr;
    logic busy, data_valid, err_timeout, err_code, req;
    logic [2:0] data;
    logic ack, a0, a1, b0, b1, c0, c1;

    // Behavioural LFSR outputs and a direct override path.
    logic       m_ack   = 1'b0;
    logic [5:0] m_rails = 6'd0;
    logic [2:0] m_s     = 3'b001;
    int         m_cnt   = 0;
    int         m_mode;
    int         m_dly;
    logic [2:0] m_seed;
    logic       m_load;
    logic       o_en, o_ack;
    logic [5:0] o_rails;

    assign ack = o_en ? o_ack : m_ack;
    assign {a0, a1, b0, b1, c0, c1} = o_en ? o_rails : m_rails;

    int         total, bad;
    int         dv_cnt    = 0;
    int         rise_bad  = 0;
    logic       req_prev  = 1'b0;
    logic [2:0] dv_log [64];

    lfsr_hs_controller #(
        .SYNC_STAGES(SYNC),
        .SETTLE     (SET),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .auto       (auto),
        .err_clr    (err_clr),
        .busy       (busy),
        .data       (data),
        .data_valid (data_valid),
        .err_timeout(err_timeout),
        .err_code   (err_code),
        .req        (req),
        .ack        (ack),
        .a0         (a0),
        .a1         (a1),
        .b0         (b0),
        .b1         (b1),
        .c0         (c0),
        .c1         (c1)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] nxt(logic [2:0] s);
        return {s[1:0], s[2] ^ s[1]};
    endfunction

    function automatic logic [5:0] enc(logic [2:0] v);
        return {~v[2], v[2], ~v[1], v[1], ~v[0], v[0]};
    endfunction

    // Modes: 0 normal, 1 never acks, 2 acks with a0=a1=1.
    always @(negedge clk) begin
        if (m_load) m_s = m_seed;
        if (req && !m_ack) begin
            if (m_mode != 1) begin
                if (m_cnt >= m_dly) begin
                    m_ack   = 1'b1;
                    m_rails = (m_mode == 2) ? 6'b11_01_10 : enc(m_s);
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
        end else if (!req && m_ack) begin
            if (m_cnt >= m_dly) begin
                m_ack   = 1'b0;
                m_rails = 6'd0;
                if (m_mode == 0) m_s = nxt(m_s);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (data_valid) begin
            if (dv_cnt < 64) dv_log[dv_cnt] = data;
            dv_cnt++;
        end
        if (req && !req_prev && ack) rise_bad++;
        req_prev = req;
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, int got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic wait_dv(string tag, int target);
        int n = 0;
        while (dv_cnt < target && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_dv_wait"}, int'(dv_cnt >= target), 1);
    endtask

    task automatic wait_idle(string tag);
        int n = 0;
        while (busy && n < 600) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic wait_err(string tag);
        int n = 0;
        while (!(err_code || err_timeout) && n < 600) begin
            tick();
            n++;
        end
        chk({tag, "_err_wait"}, int'(err_code | err_timeout), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_s;
        logic [2:0] last;
        int         n0;
        int         n;

        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        auto    = 1'b0;
        err_clr = 1'b0;
        m_mode  = 0;
        m_dly   = 2;
        m_seed  = 3'b101;
        m_load  = 1'b0;
        o_en    = 1'b0;
        o_ack   = 1'b0;
        o_rails = 6'd0;
        tick(3);

        chk("rst_req", int'(req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_dv", int'(data_valid), 0);
        chk("rst_eto", int'(err_timeout), 0);
        chk("rst_ecode", int'(err_code), 0);

        rst_n  = 1'b1;
        m_load = 1'b1;
        tick();
        m_load = 1'b0;
        tick(3);

        // Single handshake, ack 3 cycles after req with 101.
        exp_s = 3'b101;
        n0 = dv_cnt;
        pulse_start();
        chk("t1_req_lat", int'(req), 1);
        wait_dv("t1", n0 + 1);
        chk("t1_data_log", int'(dv_log[n0]), 3'b101);
        chk("t1_data", int'(data), 3'b101);
        chk("t1_req_lo", int'(req), 0);
        exp_s = nxt(exp_s);
        last = 3'b101;
        wait_idle("t1");
        tick(5);
        chk("t1_dv_count", dv_cnt - n0, 1);

        // No ack: timeout in REQ_HI.
        m_mode = 1;
        pulse_start();
        n = 0;
        while (req && n < 600) begin
            tick();
            n++;
        end
        chk("t2_req_len", int'(n >= TMO && n <= TMO + 2), 1);
        chk("t2_eto", int'(err_timeout), 1);
        chk("t2_ecode", int'(err_code), 0);
        chk("t2_busy_err", int'(busy), 1);
        chk("t2_req", int'(req), 0);
        pulse_clr();
        wait_idle("t2");
        chk("t2_eto_clr", int'(err_timeout), 0);
        m_mode = 0;

        // Illegal rail pair.
        m_mode = 2;
        m_dly = $urandom_range(1, 5);
        n0 = dv_cnt;
        pulse_start();
        wait_err("t3");
        tick();
        chk("t3_ecode", int'(err_code), 1);
        chk("t3_eto", int'(err_timeout), 0);
        chk("t3_req", int'(req), 0);
        chk("t3_data_hold", int'(data), int'(last));
        chk("t3_no_dv", dv_cnt - n0, 0);
        pulse_clr();
        wait_idle("t3");
        chk("t3_ecode_clr", int'(err_code), 0);
        m_mode = 0;

        // Auto mode, four handshakes from a random seed.
        m_seed = 3'($urandom_range(1, 7));
        m_load = 1'b1;
        tick();
        m_load = 1'b0;
        exp_s = m_seed;
        m_dly = $urandom_range(1, 5);
        auto = 1'b1;
        n0 = dv_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            wait_dv("t4", n0 + i + 1);
            if (i == 3) auto = 1'b0;
            m_dly = $urandom_range(1, 5);
        end
        wait_idle("t4");
        tick(10);
        chk("t4_dv_count", dv_cnt - n0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_data%0d", i), int'(dv_log[n0 + i]), int'(exp_s));
            last = exp_s;
            exp_s = nxt(exp_s);
        end
        chk("t4_data_out", int'(data), int'(last));

        // Start pulse in REQ_LO is ignored.
        m_dly = $urandom_range(1, 5);
        n0 = dv_cnt;
        pulse_start();
        wait_dv("t6", n0 + 1);
        pulse_start();
        wait_idle("t6");
        tick(30);
        chk("t6_dv_count", dv_cnt - n0, 1);
        chk("t6_data", int'(dv_log[n0]), int'(exp_s));
        chk("t6_busy", int'(busy), 0);
        exp_s = nxt(exp_s);

        // Async reset in REQ_HI, then start with ack held high.
        m_mode = 1;
        pulse_start();
        tick(3);
        chk("t5_req_hi", int'(req), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_req_async", int'(req), 0);
        o_en  = 1'b1;
        o_ack = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(SYNC + 2);
        pulse_start();
        tick(5);
        chk("t5_busy", int'(busy), 0);
        chk("t5_req", int'(req), 0);
        chk("t5_data_rst", int'(data), 0);
        o_en   = 1'b0;
        o_ack  = 1'b0;
        m_mode = 0;
        tick(5);

        chk("req_rise_ack", rise_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
